counter_bn: RTL and testbench
=============================

// Module: counter_bn
// PURPOSE
//  Parametrised successor to the 4-bit mode counter: WIDTH-bit counter with
//  programmable modulus, configurable down-step, wrap or saturate, and cascade
//  support (count-enable in, terminal-count out) so N stages chain into wider
//  counters. It is the standard counter primitive for the Qflow test designs.
// PARAMETERS
//  WIDTH      8          counter width in bits (>=2)
//  MAX_COUNT  2**WIDTH-1 terminal value; count range 0..MAX_COUNT (modulus M=MAX_COUNT+1)
//  DN_STEP    3          decrement used in mode 2'b10 (1..MAX_COUNT)
//  SATURATE   0          0: wrap modulo M; 1: stop at the bound instead of wrapping
// PORTS
//  bn_clk     in   1      clock, all state updates on rising edge
//  bn_reset   in   1      synchronous reset, active-low
//  bn_enable  in   1      block enable; 0 clears the counter
//  bn_ci      in   1      cascade count-enable (tie 1 for a single stage)
//  bn_mode    in   2      00 up+1, 01 down-1, 10 down-DN_STEP, 11 parallel load
//  bn_D       in   WIDTH  parallel load data
//  bn_Q       out  WIDTH  count value (registered)
//  bn_load    out  1      registered: high the cycle after a load was taken
//  bn_rco     out  1      registered ripple-carry: one-cycle pulse after a wrap/saturate event
//  bn_tc      out  1      combinational terminal count for cascading (see below)
// BEHAVIOUR
//  - Reset (bn_reset==0 at rising edge): bn_Q=0, bn_load=0, bn_rco=0. Reset overrides everything.
//  - bn_enable==0 (reset inactive): bn_Q=0, bn_load=0, bn_rco=0 next cycle; bn_tc=0.
//  - bn_enable==1, bn_ci==0: bn_Q holds; bn_load=0, bn_rco=0. Mode 11 still loads (load ignores ci).
//  - bn_enable==1, bn_ci==1, latency 1 cycle, per mode:
//    00: Q==MAX_COUNT -> Q=0 (SATURATE: hold MAX_COUNT), rco=1; else Q+1, rco=0.
//    01: Q==0 -> Q=MAX_COUNT (SATURATE: hold 0), rco=1; else Q-1, rco=0.
//    10: Q<DN_STEP -> Q=Q+M-DN_STEP (SATURATE: Q=0), rco=1; else Q-DN_STEP, rco=0.
//    11: Q=min(bn_D,MAX_COUNT) (clamp out-of-range data), load=1, rco=0.
//    load=0 in modes 00/01/10.
//  - Arithmetic in WIDTH+1 bits internally; no result ever leaves 0..MAX_COUNT.
//  - bn_tc = bn_enable & bn_ci & wrap-condition of current mode on current Q
//    (mode 00: Q==MAX_COUNT; 01: Q==0; 10: Q<DN_STEP; 11: 0). Drives next stage's bn_ci.
//    In SATURATE mode bn_tc still flags the bound condition.
//  - bn_rco equals bn_tc registered (same cycle the wrapped value appears on bn_Q).
//  - Mode change takes effect on the next edge; no hidden state beyond bn_Q/bn_load/bn_rco.
//  - Reset mid-count: next edge Q=0 regardless of mode, ci or pending wrap.
// STRUCTURE
//  - Package counter_pkg: localparams MODE_UP=2'b00, MODE_DN=2'b01, MODE_DN_STEP=2'b10,
//    MODE_LOAD=2'b11, shared with testbench and cascade wrappers.
//  - Sub-module counter_bn_next (combinational): inputs Q, mode, D; outputs next_q, wrap.
//    Owns all modulus/step/saturate arithmetic; counter_bn holds registers and enable/ci gating.
//  - Elaboration checks: MAX_COUNT < 2**WIDTH, 1 <= DN_STEP <= MAX_COUNT.
// TESTING (defaults WIDTH=8, MAX=255, DN_STEP=3 unless stated)
//  - Reset: count to 7, drop bn_reset for 1 edge -> Q=0, load=0, rco=0; enable=0 -> Q=0.
//  - Up wrap: load 254, mode 00 -> Q 255 (tc=1), then 0 with rco=1 for one cycle; SATURATE=1 -> Q stays 255, rco=1.
//  - Down-step: load 4, mode 10 -> Q 1, then 254 (1+256-3) with rco=1; MAX=9 build: 1 -> 8.
//  - Load clamp: MAX_COUNT=9, D=13, mode 11 -> Q=9, load=1 next cycle, rco=0; mode 00 next -> load=0.
//  - Cascade: two 4-bit stages (MAX=15), low bn_tc -> high bn_ci, mode 00 from 0 -> 8-bit value
//    increments each cycle; 0x0F -> 0x10; 0xFF -> 0x00 with high-stage rco=1.
//  - ci gating: ci=0 in modes 00/01/10 -> Q holds, rco=0; mode 01 from 0 with ci=1 -> Q=255, rco=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared mode encodings for counter_bn, its next-state logic, cascade wrappers and benches.
package counter_pkg;
  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DN      = 2'b01;
  localparam logic [1:0] MODE_DN_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD    = 2'b11;
endpackage

// File: rtl/counter_bn_next.sv
// Combinational next-count logic: modulus, down-step, saturate and load clamp.
// Arithmetic is done one bit wider than the counter so no intermediate overflows.
module counter_bn_next
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int DN_STEP   = 3,
  parameter int SATURATE  = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap
);
  localparam bit             SAT    = (SATURATE != 0);
  localparam logic [WIDTH:0] ONE_E  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] MAX_E  = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0] MOD_E  = MAX_E + ONE_E;
  localparam logic [WIDTH:0] STEP_E = (WIDTH+1)'(DN_STEP);

  logic [WIDTH:0] q_e, d_e, res_e;
  logic           unused_msb;

  // Per-mode successor; wrap flags the bound condition whether or not we saturate
  always_comb begin
    q_e   = {1'b0, q};
    d_e   = {1'b0, d};
    res_e = q_e;
    wrap  = 1'b0;
    case (mode)
      MODE_UP: begin
        if (q_e == MAX_E) begin
          wrap  = 1'b1;
          res_e = SAT ? MAX_E : '0;
        end else begin
          res_e = q_e + ONE_E;
        end
      end
      MODE_DN: begin
        if (q_e == '0) begin
          wrap  = 1'b1;
          res_e = SAT ? '0 : MAX_E;
        end else begin
          res_e = q_e - ONE_E;
        end
      end
      MODE_DN_STEP: begin
        if (q_e < STEP_E) begin
          wrap  = 1'b1;
          // (M - step) first keeps the sum inside WIDTH+1 bits
          res_e = SAT ? '0 : (MOD_E - STEP_E) + q_e;
        end else begin
          res_e = q_e - STEP_E;
        end
      end
      default: begin
        // load: out-of-range data clamps to the terminal value
        res_e = (d_e > MAX_E) ? MAX_E : d_e;
      end
    endcase
  end

  assign next_q     = res_e[WIDTH-1:0];
  assign unused_msb = res_e[WIDTH];
endmodule

// File: rtl/counter_bn.sv
// Cascadable WIDTH-bit mode counter: registers plus enable / count-enable gating.
// bn_tc is combinational so a chain of stages resolves within one cycle.
module counter_bn
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int DN_STEP   = 3,
  parameter int SATURATE  = 0
) (
  input  logic             bn_clk,
  input  logic             bn_reset,
  input  logic             bn_enable,
  input  logic             bn_ci,
  input  logic [1:0]       bn_mode,
  input  logic [WIDTH-1:0] bn_D,
  output logic [WIDTH-1:0] bn_Q,
  output logic             bn_load,
  output logic             bn_rco,
  output logic             bn_tc
);
  if (WIDTH < 2) begin : g_bad_width
    $error("counter_bn: WIDTH must be >= 2");
  end
  if (MAX_COUNT < 1 || MAX_COUNT >= 2**WIDTH) begin : g_bad_max
    $error("counter_bn: MAX_COUNT must lie in 1..2**WIDTH-1");
  end
  if (DN_STEP < 1 || DN_STEP > MAX_COUNT) begin : g_bad_step
    $error("counter_bn: DN_STEP must lie in 1..MAX_COUNT");
  end

  logic [WIDTH-1:0] q_q, q_d, nxt_q;
  logic             load_q, load_d, rco_q, rco_d, wrap;

  counter_bn_next #(
    .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .DN_STEP(DN_STEP), .SATURATE(SATURATE)
  ) u_next (
    .q(q_q), .mode(bn_mode), .d(bn_D), .next_q(nxt_q), .wrap(wrap)
  );

  // wrap is already 0 in load mode, so tc needs no mode term
  assign bn_tc = bn_enable & bn_ci & wrap;

  // Enable clears, load ignores ci, counting modes step only with ci
  always_comb begin
    q_d    = q_q;
    load_d = 1'b0;
    rco_d  = 1'b0;
    if (!bn_enable) begin
      q_d = '0;
    end else if (bn_mode == MODE_LOAD) begin
      q_d    = nxt_q;
      load_d = 1'b1;
    end else if (bn_ci) begin
      q_d   = nxt_q;
      rco_d = wrap;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge bn_clk) begin
    if (!bn_reset) begin
      q_q    <= '0;
      load_q <= 1'b0;
      rco_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      load_q <= load_d;
      rco_q  <= rco_d;
    end
  end

  assign bn_Q    = q_q;
  assign bn_load = load_q;
  assign bn_rco  = rco_q;
endmodule

// File: tb/tb_counter_bn.sv
// Scoreboard bench for counter_bn. Four configurations share one stimulus stream:
//  0: defaults, 1: SATURATE=1, 2: MAX_COUNT=9, 3: two cascaded 4-bit stages
//  (DN_STEP=1) which together behave as one 8-bit wrap counter with step 1.
module tb_counter_bn;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, ci;
  logic [1:0] mode;
  logic [7:0] d;

  always #5 clk = ~clk;

  logic [7:0] qa, qb, qc;
  logic [3:0] q_lo, q_hi;
  logic       ld_a, ld_b, ld_c, ld_lo, ld_hi;
  logic       rc_a, rc_b, rc_c, rc_lo, rc_hi;
  logic       tc_a, tc_b, tc_c, tc_lo, tc_hi;

  counter_bn u_a (.bn_clk(clk), .bn_reset(rst_n), .bn_enable(en), .bn_ci(ci), .bn_mode(mode),
                  .bn_D(d), .bn_Q(qa), .bn_load(ld_a), .bn_rco(rc_a), .bn_tc(tc_a));
  counter_bn #(.SATURATE(1)) u_b (.bn_clk(clk), .bn_reset(rst_n), .bn_enable(en), .bn_ci(ci),
                  .bn_mode(mode), .bn_D(d), .bn_Q(qb), .bn_load(ld_b), .bn_rco(rc_b), .bn_tc(tc_b));
  counter_bn #(.MAX_COUNT(9)) u_c (.bn_clk(clk), .bn_reset(rst_n), .bn_enable(en), .bn_ci(ci),
                  .bn_mode(mode), .bn_D(d), .bn_Q(qc), .bn_load(ld_c), .bn_rco(rc_c), .bn_tc(tc_c));
  counter_bn #(.WIDTH(4), .MAX_COUNT(15), .DN_STEP(1)) u_lo (.bn_clk(clk), .bn_reset(rst_n),
                  .bn_enable(en), .bn_ci(ci), .bn_mode(mode), .bn_D(d[3:0]), .bn_Q(q_lo),
                  .bn_load(ld_lo), .bn_rco(rc_lo), .bn_tc(tc_lo));
  counter_bn #(.WIDTH(4), .MAX_COUNT(15), .DN_STEP(1)) u_hi (.bn_clk(clk), .bn_reset(rst_n),
                  .bn_enable(en), .bn_ci(tc_lo), .bn_mode(mode), .bn_D(d[7:4]), .bn_Q(q_hi),
                  .bn_load(ld_hi), .bn_rco(rc_hi), .bn_tc(tc_hi));

  logic [3:0][7:0] act_q;
  logic [3:0]      act_ld, act_rc, act_tc;
  assign act_q  = {q_hi, q_lo, qc, qb, qa};
  assign act_ld = {ld_hi, ld_c, ld_b, ld_a};
  assign act_rc = {rc_hi, rc_c, rc_b, rc_a};
  assign act_tc = {tc_hi, tc_c, tc_b, tc_a};

  // reference parameters per configuration
  int MAXV[4] = '{255, 255, 9, 255};
  int STEP[4] = '{3, 3, 3, 1};
  int SATV[4] = '{0, 1, 0, 0};

  typedef struct packed {
    logic            chk;
    logic [3:0][7:0] q;
    logic [3:0]      ld, rc;
  } reg_exp_t;
  typedef struct packed {
    logic       chk;
    logic [3:0] tc;
  } tc_exp_t;

  reg_exp_t rq[$];
  tc_exp_t  tq[$];

  int  mq[4];
  bit  mvalid = 1'b0;
  int  n_chk = 0, n_pass = 0;

  function automatic bit at_bound(int q, int md, int mx, int st);
    case (md)
      0:       return q == mx;
      1:       return q == 0;
      2:       return q < st;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string name, int idx, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[cfg%0d] got %0d want %0d at %0t", name, idx, act, exp, $time);
  endtask

  // Apply one cycle of inputs and push the model's expectations
  task automatic drive(bit r, bit e, bit c, logic [1:0] m, logic [7:0] dd);
    reg_exp_t re;
    tc_exp_t  te;
    @(negedge clk);
    #1;
    rst_n = r; en = e; ci = c; mode = m; d = dd;
    te.chk = mvalid;
    re.chk = mvalid | !r;
    for (int i = 0; i < 4; i++) begin
      int q, mx, st, nq;
      bit ld, rc;
      q = mq[i]; mx = MAXV[i]; st = STEP[i];
      te.tc[i] = e & c & at_bound(q, int'(m), mx, st);
      nq = q; ld = 0; rc = 0;
      if (!r || !e) nq = 0;
      else if (m == MODE_LOAD) begin
        nq = (int'(dd) > mx) ? mx : int'(dd);
        ld = 1;
      end else if (c) begin
        rc = at_bound(q, int'(m), mx, st);
        case (int'(m))
          0: nq = rc ? (SATV[i] != 0 ? mx : 0) : q + 1;
          1: nq = rc ? (SATV[i] != 0 ? 0 : mx) : q - 1;
          default: nq = rc ? (SATV[i] != 0 ? 0 : q + (mx + 1) - st) : q - st;
        endcase
      end
      mq[i] = nq;
      re.q[i] = 8'(nq); re.ld[i] = ld; re.rc[i] = rc;
    end
    if (!r) mvalid = 1'b1;
    tq.push_back(te);
    rq.push_back(re);
  endtask

  // Monitor: tc mid-cycle after inputs settle, registered outputs just after the edge
  initial begin
    tc_exp_t  te;
    reg_exp_t re;
    forever begin
      @(negedge clk);
      #3;
      if (tq.size() > 0) begin
        te = tq.pop_front();
        if (te.chk)
          for (int i = 0; i < 4; i++) check("tc", i, int'(act_tc[i]), int'(te.tc[i]));
      end
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        re = rq.pop_front();
        if (re.chk)
          for (int i = 0; i < 4; i++) begin
            check("q", i, int'(act_q[i]), int'(re.q[i]));
            check("load", i, int'(act_ld[i]), int'(re.ld[i]));
            check("rco", i, int'(act_rc[i]), int'(re.rc[i]));
          end
      end
    end
  end

  initial begin
    logic [7:0] edges[12];
    edges = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15, 8'd254, 8'd255};
    rst_n = 1'b0; en = 1'b0; ci = 1'b0; mode = MODE_UP; d = '0;
    // reset, count to 7, reset mid-count, enable low
    drive(0, 1, 1, MODE_UP, 0);
    for (int i = 0; i < 7; i++) drive(1, 1, 1, MODE_UP, 0);
    drive(0, 1, 1, MODE_UP, 0);
    drive(1, 0, 1, MODE_UP, 0);
    // up wrap / saturate at 255
    drive(1, 1, 1, MODE_LOAD, 254);
    repeat (3) drive(1, 1, 1, MODE_UP, 0);
    // down-step wrap
    drive(1, 1, 1, MODE_LOAD, 4);
    repeat (3) drive(1, 1, 1, MODE_DN_STEP, 0);
    // load clamp then load clears
    drive(1, 1, 1, MODE_LOAD, 13);
    drive(1, 1, 1, MODE_UP, 0);
    // ci gating, load ignores ci
    drive(1, 1, 1, MODE_LOAD, 5);
    drive(1, 1, 0, MODE_UP, 0);
    drive(1, 1, 0, MODE_DN, 0);
    drive(1, 1, 0, MODE_DN_STEP, 0);
    drive(1, 1, 0, MODE_LOAD, 7);
    drive(1, 1, 1, MODE_LOAD, 0);
    drive(1, 1, 1, MODE_DN, 0);
    // cascade carry 0x0F -> 0x10 and 0xFF -> 0x00
    drive(1, 1, 1, MODE_LOAD, 8'h0E);
    repeat (2) drive(1, 1, 1, MODE_UP, 0);
    drive(1, 1, 1, MODE_LOAD, 8'hFF);
    repeat (2) drive(1, 1, 1, MODE_UP, 0);
    // random traffic, data biased toward the bounds
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] dd;
      dd = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 11)] : 8'($urandom);
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
            2'($urandom), dd);
    end
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
